prog_inst_mem: RTL and testbench

- Parametrised, clocked instruction memory for the lab CPU; replaces the fixed, combinational, init-only instruction store.
- Provides a registered fetch port with request/valid handshake and a word-write programming port, so programs load at run time instead of being hard-coded.
- A boot state machine fills every word with NOP after reset.
- Sits between the PC/fetch stage and the test bench or loader.

---
 rtl/prog_inst_mem.sv | 138 +++++++++++++
 tb/tb_prog_inst_mem.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/prog_inst_mem.sv
// Clocked instruction memory for the lab CPU: boot-time NOP fill, registered
// fetch port with misalignment flag, and a word-write programming port.
module prog_inst_mem #(
    parameter int              ADDR_W     = 32,
    parameter int              DEPTH_LOG2 = 8,
    parameter int              DATA_W     = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = {DATA_W{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_req,
    input  logic [ADDR_W-1:0]     fetch_addr,
    output logic                  fetch_valid,
    output logic [DATA_W-1:0]     fetch_inst,
    output logic                  fetch_misalign,
    output logic                  busy,
    input  logic                  prog_en,
    input  logic                  prog_we,
    input  logic [DEPTH_LOG2-1:0] prog_addr,
    input  logic [DATA_W-1:0]     prog_data,
    output logic                  prog_ack
);

    localparam int DEPTH = 32'd1 << DEPTH_LOG2;

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PROG  = 2'd2;

    localparam logic [DEPTH_LOG2-1:0] CNT_ONE  = DEPTH_LOG2'(1'b1);
    localparam logic [DEPTH_LOG2-1:0] CNT_LAST = {DEPTH_LOG2{1'b1}};

    logic [DATA_W-1:0]     mem [0:DEPTH-1];
    logic [1:0]            state_r;
    logic [DEPTH_LOG2-1:0] clr_cnt_r;

    logic                  mem_we_s;
    logic [DEPTH_LOG2-1:0] mem_waddr_s;
    logic [DATA_W-1:0]     mem_wdata_s;
    logic [DEPTH_LOG2-1:0] fetch_idx_s;
    logic                  unused_addr_hi;

    // Upper address bits are deliberately dropped so fetches wrap around the array.
    assign fetch_idx_s    = fetch_addr[DEPTH_LOG2+1:2];
    assign unused_addr_hi = ^fetch_addr[ADDR_W-1:DEPTH_LOG2+2];

    // Busy covers both states that own the single write port.
    assign busy = (state_r == ST_CLEAR) || (state_r == ST_PROG);

    // Select the single write source: clear sweep or programming port.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = clr_cnt_r;
        mem_wdata_s = NOP_WORD;
        case (state_r)
            ST_CLEAR: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = clr_cnt_r;
                mem_wdata_s = NOP_WORD;
            end
            ST_PROG: begin
                if (prog_we) begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = prog_addr;
                    mem_wdata_s = prog_data;
                end else begin
                    mem_we_s    = 1'b0;
                end
            end
            default: begin
                mem_we_s = 1'b0;
            end
        endcase
    end

    // Synchronous single-port RAM write; contents are not reset, CLEAR does that.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // State machine plus registered fetch and programming-acknowledge outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_CLEAR;
            clr_cnt_r      <= {DEPTH_LOG2{1'b0}};
            fetch_valid    <= 1'b0;
            fetch_misalign <= 1'b0;
            fetch_inst     <= NOP_WORD;
            prog_ack       <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    fetch_valid    <= 1'b0;
                    fetch_misalign <= 1'b0;
                    prog_ack       <= 1'b0;
                    clr_cnt_r      <= clr_cnt_r + CNT_ONE;
                    if (clr_cnt_r == CNT_LAST) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    prog_ack <= 1'b0;
                    if (prog_en) begin
                        // Programming wins over a simultaneous fetch request.
                        state_r        <= ST_PROG;
                        fetch_valid    <= 1'b0;
                        fetch_misalign <= 1'b0;
                    end else if (fetch_req) begin
                        fetch_valid    <= 1'b1;
                        fetch_misalign <= |fetch_addr[1:0];
                        fetch_inst     <= mem[fetch_idx_s];
                    end else begin
                        fetch_valid    <= 1'b0;
                        fetch_misalign <= 1'b0;
                    end
                end
                ST_PROG: begin
                    fetch_valid    <= 1'b0;
                    fetch_misalign <= 1'b0;
                    prog_ack       <= prog_we;
                    if (!prog_en) begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r        <= ST_CLEAR;
                    clr_cnt_r      <= {DEPTH_LOG2{1'b0}};
                    fetch_valid    <= 1'b0;
                    fetch_misalign <= 1'b0;
                    prog_ack       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_inst_mem.sv
// Directed self-checking bench for prog_inst_mem with an 8-word array.
module tb_prog_inst_mem;

    localparam int ADDR_W     = 32;
    localparam int DEPTH_LOG2 = 3;
    localparam int DATA_W     = 32;

    logic                  clk;
    logic                  rst_n;
    logic                  fetch_req;
    logic [ADDR_W-1:0]     fetch_addr;
    logic                  fetch_valid;
    logic [DATA_W-1:0]     fetch_inst;
    logic                  fetch_misalign;
    logic                  busy;
    logic                  prog_en;
    logic                  prog_we;
    logic [DEPTH_LOG2-1:0] prog_addr;
    logic [DATA_W-1:0]     prog_data;
    logic                  prog_ack;

    int total;
    int bad;

    prog_inst_mem #(
        .ADDR_W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2), .DATA_W(DATA_W), .NOP_WORD(32'h0000_0000)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(fetch_valid), .fetch_inst(fetch_inst), .fetch_misalign(fetch_misalign),
        .busy(busy),
        .prog_en(prog_en), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_ack(prog_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = 32'h0; prog_en = 1'b0;
        prog_we = 1'b0; prog_addr = 3'd0; prog_data = 32'h0;
        #22;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b exp=1", busy); end
        total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", fetch_valid); end
        total++; if (fetch_misalign !== 1'b0) begin bad++; $display("FAIL reset_misalign got=%b exp=0", fetch_misalign); end
        total++; if (fetch_inst !== 32'h0000_0000) begin bad++; $display("FAIL reset_inst got=%h exp=00000000", fetch_inst); end
        total++; if (prog_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", prog_ack); end
    endtask

    // Expects the caller to be mid-cycle with rst_n just released.
    task automatic check_clear_sweep(input string tag);
        for (int k = 1; k <= 8; k++) begin
            step();
            total++;
            if (busy !== (k < 8)) begin
                bad++; $display("FAIL %s_busy edge=%0d got=%b exp=%b", tag, k, busy, (k < 8));
            end
            total++;
            if (fetch_valid !== 1'b0) begin
                bad++; $display("FAIL %s_valid edge=%0d got=%b exp=0", tag, k, fetch_valid);
            end
        end
    endtask

    task automatic test_boot_fill();
        fetch_req = 1'b1; fetch_addr = 32'h1C;   // must be ignored during CLEAR
        rst_n = 1'b1;
        check_clear_sweep("boot");
        step();
        total++; if (fetch_valid !== 1'b1) begin bad++; $display("FAIL boot_fetch_valid got=%b exp=1", fetch_valid); end
        total++; if (fetch_inst !== 32'h0000_0000) begin bad++; $display("FAIL boot_fetch_inst got=%h exp=00000000", fetch_inst); end
        fetch_req = 1'b0;
        step();
        total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b exp=0", fetch_valid); end
    endtask

    task automatic test_program_fetch();
        prog_en = 1'b1;
        step();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL prog_busy got=%b exp=1", busy); end
        prog_we = 1'b1; prog_addr = 3'd1; prog_data = 32'h8C1F_0000;
        step();
        total++; if (prog_ack !== 1'b1) begin bad++; $display("FAIL ack_w1 got=%b exp=1", prog_ack); end
        prog_we = 1'b0;
        step();
        total++; if (prog_ack !== 1'b0) begin bad++; $display("FAIL ack_idle got=%b exp=0", prog_ack); end
        // write on the same edge that leaves PROG
        prog_en = 1'b0; prog_we = 1'b1; prog_addr = 3'd2; prog_data = 32'h001F_F022;
        step();
        total++; if (prog_ack !== 1'b1) begin bad++; $display("FAIL ack_exit got=%b exp=1", prog_ack); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL exit_busy got=%b exp=0", busy); end
        prog_we = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h04;
        step();
        total++; if (prog_ack !== 1'b0) begin bad++; $display("FAIL ack_drop got=%b exp=0", prog_ack); end
        total++; if (fetch_valid !== 1'b1 || fetch_inst !== 32'h8C1F_0000)
            begin bad++; $display("FAIL b2b_first got=%b/%h exp=1/8c1f0000", fetch_valid, fetch_inst); end
        fetch_addr = 32'h08;
        step();
        total++; if (fetch_valid !== 1'b1 || fetch_inst !== 32'h001F_F022)
            begin bad++; $display("FAIL b2b_second got=%b/%h exp=1/001ff022", fetch_valid, fetch_inst); end
    endtask

    task automatic test_misalign_wrap();
        fetch_req = 1'b1; fetch_addr = 32'h06;
        step();
        total++; if (fetch_misalign !== 1'b1 || fetch_inst !== 32'h8C1F_0000)
            begin bad++; $display("FAIL misalign_06 got=%b/%h exp=1/8c1f0000", fetch_misalign, fetch_inst); end
        fetch_addr = 32'h04;
        step();
        total++; if (fetch_misalign !== 1'b0) begin bad++; $display("FAIL misalign_04 got=%b exp=0", fetch_misalign); end
        fetch_addr = 32'h404;
        step();
        total++; if (fetch_inst !== 32'h8C1F_0000) begin bad++; $display("FAIL wrap_404 got=%h exp=8c1f0000", fetch_inst); end
        fetch_addr = 32'h2B;   // word 2 after wrap, misaligned
        step();
        total++; if (fetch_inst !== 32'h001F_F022 || fetch_misalign !== 1'b1)
            begin bad++; $display("FAIL wrap_2b got=%h/%b exp=001ff022/1", fetch_inst, fetch_misalign); end
        fetch_req = 1'b0; fetch_addr = 32'h00;
        step();
        total++; if (fetch_valid !== 1'b0 || fetch_misalign !== 1'b0 || fetch_inst !== 32'h001F_F022)
            begin bad++; $display("FAIL hold got=%b/%b/%h exp=0/0/001ff022", fetch_valid, fetch_misalign, fetch_inst); end
    endtask

    task automatic test_collision();
        fetch_req = 1'b1; fetch_addr = 32'h04; prog_en = 1'b1;
        step();
        total++; if (fetch_valid !== 1'b0 || busy !== 1'b1)
            begin bad++; $display("FAIL collide got=%b/%b exp=0/1", fetch_valid, busy); end
        prog_we = 1'b1; prog_addr = 3'd3; prog_data = 32'h021F_E820;
        step();
        total++; if (prog_ack !== 1'b1 || fetch_valid !== 1'b0)
            begin bad++; $display("FAIL collide_write got=%b/%b exp=1/0", prog_ack, fetch_valid); end
        prog_we = 1'b0; prog_en = 1'b0;
        step();
        total++; if (busy !== 1'b0 || fetch_valid !== 1'b0)
            begin bad++; $display("FAIL collide_exit got=%b/%b exp=0/0", busy, fetch_valid); end
        fetch_addr = 32'h0C;
        step();
        total++; if (fetch_valid !== 1'b1 || fetch_inst !== 32'h021F_E820)
            begin bad++; $display("FAIL raw_0c got=%b/%h exp=1/021fe820", fetch_valid, fetch_inst); end
        fetch_req = 1'b0;
        step();
    endtask

    task automatic test_reset_midop();
        prog_en = 1'b1;
        step();
        prog_we = 1'b1; prog_addr = 3'd5; prog_data = 32'hDEAD_BEEF;
        step();
        #2 rst_n = 1'b0;
        #1;
        total++; if (prog_ack !== 1'b0 || busy !== 1'b1 || fetch_valid !== 1'b0 || fetch_inst !== 32'h0)
            begin bad++; $display("FAIL rst_prog got=%b/%b/%b/%h exp=0/1/0/00000000", prog_ack, busy, fetch_valid, fetch_inst); end
        prog_en = 1'b0; prog_we = 1'b0;
        #1 rst_n = 1'b1;
        step(); step(); step();   // clr_cnt now 3
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_clear_busy got=%b exp=1", busy); end
        #1 rst_n = 1'b1;
        check_clear_sweep("reclear");
        fetch_req = 1'b1; fetch_addr = 32'h04;
        step();
        total++; if (fetch_valid !== 1'b1 || fetch_inst !== 32'h0000_0000)
            begin bad++; $display("FAIL reclear_04 got=%b/%h exp=1/00000000", fetch_valid, fetch_inst); end
        fetch_addr = 32'h0C;
        step();
        total++; if (fetch_inst !== 32'h0000_0000) begin bad++; $display("FAIL reclear_0c got=%h exp=00000000", fetch_inst); end
        fetch_req = 1'b0;
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_boot_fill();
        test_program_fetch();
        test_misalign_wrap();
        test_collision();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
